// File: rtl/audio_pkg.sv
// audio_pkg: constants and types shared by the audio feed blocks.
//   FRAME_CLK : clocks per stereo frame (two 512-clock half-frames)
//   SAMPLE_W  : width of one channel sample, two's complement
//   state_t   : frame scheduler states
package audio_pkg;

  localparam int FRAME_CLK = 1024;
  localparam int SAMPLE_W  = 16;

  typedef enum logic {
    PRIME = 1'b0,
    RUN   = 1'b1
  } state_t;

endpackage

// File: rtl/audio_fifo.sv
// audio_fifo: small synchronous FIFO holding stereo sample pairs.
// Ports:
//   clock  in   system clock, rising edge
//   reset  in   synchronous active-low reset, empties the FIFO
//   push   in   write wdata this edge (caller guarantees not full)
//   pop    in   advance the read pointer this edge (caller guarantees not empty)
//   wdata  in   WIDTH-bit word to write
//   rdata  out  head of the FIFO, valid while level != 0
//   level  out  occupancy 0..DEPTH
module audio_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;

  // Pointers wrap naturally because DEPTH is a power of two; level is kept
  // one bit wider so full and empty stay distinguishable.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop)  rp <= rp + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Storage carries no reset; stale words are unreachable once pointers clear.
  always_ff @(posedge clock) begin
    if (push && reset) mem[wp] <= wdata;
  end

  assign rdata = mem[rp];

endmodule

// File: rtl/i2s_feed.sv
// i2s_feed: frame scheduler and sample buffer in front of the I2S serializer.
// Buffers stereo samples from one producer and presents one pair per frame on
// l/r, held for a whole frame, with start-up priming, underflow recovery and mute.
// Ports:
//   clock  in   system clock, rising edge
//   reset  in   synchronous active-low reset
//   valid  in   producer offers dl/dr
//   ready  out  FIFO can accept (transfer on valid & ready)
//   dl/dr  in   left/right sample
//   mute   in   zero the output value, sampled at the frame strobe
//   clear  in   one-cycle pulse, zeroes ucnt
//   l/r    out  sample pair to the serializer
//   fs     out  one-cycle strobe coincident with a new l/r
//   level  out  FIFO occupancy 0..DEPTH
//   ucnt   out  saturating underflow count
module i2s_feed
  import audio_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int FRAME = FRAME_CLK
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    valid,
  output logic                    ready,
  input  logic [SAMPLE_W-1:0]     dl,
  input  logic [SAMPLE_W-1:0]     dr,
  input  logic                    mute,
  input  logic                    clear,
  output logic [SAMPLE_W-1:0]     l,
  output logic [SAMPLE_W-1:0]     r,
  output logic                    fs,
  output logic [$clog2(DEPTH):0]  level,
  output logic [7:0]              ucnt
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam int PW = (FRAME > 1) ? $clog2(FRAME) : 1;

  logic [PW-1:0]           pc;
  logic                    st;
  logic                    push;
  logic                    pop;
  logic                    load;
  logic                    load_head;
  logic                    uinc;
  logic [2*SAMPLE_W-1:0]   head;
  state_t                  state;
  state_t                  state_n;

  // ready depends only on registered level; a same-cycle pop never raises it.
  assign ready = (level != LW'(DEPTH));
  assign push  = valid & ready;
  assign st    = (pc == PW'(FRAME - 1));

  audio_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (2 * SAMPLE_W)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata ({dl, dr}),
    .rdata (head),
    .level (level)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      pc <= '0;
    end else if (st) begin
      pc <= '0;
    end else begin
      pc <= pc + PW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) state <= PRIME;
    else        state <= state_n;
  end

  // Everything happens at the frame strobe. Mute only affects the value
  // loaded, never pop or state decisions, so the producer rate is kept.
  always_comb begin
    state_n   = state;
    pop       = 1'b0;
    load      = 1'b0;
    load_head = 1'b0;
    uinc      = 1'b0;
    if (st) begin
      case (state)
        PRIME: begin
          load = 1'b1;
          if (level >= LW'(DEPTH / 2)) begin
            pop       = 1'b1;
            load_head = 1'b1;
            state_n   = RUN;
          end
        end
        RUN: begin
          if (level != '0) begin
            pop       = 1'b1;
            load      = 1'b1;
            load_head = 1'b1;
          end else begin
            // Underflow: hold the last pair unless muted.
            load    = mute;
            uinc    = 1'b1;
            state_n = PRIME;
          end
        end
        default: state_n = PRIME;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      l  <= '0;
      r  <= '0;
      fs <= 1'b0;
    end else begin
      fs <= st;
      if (load) begin
        if (load_head && !mute) begin
          l <= head[2*SAMPLE_W-1:SAMPLE_W];
          r <= head[SAMPLE_W-1:0];
        end else begin
          l <= '0;
          r <= '0;
        end
      end
    end
  end

  // clear wins over a same-cycle increment.
  always_ff @(posedge clock) begin
    if (!reset || clear) begin
      ucnt <= '0;
    end else if (uinc && (ucnt != 8'hFF)) begin
      ucnt <= ucnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_i2s_feed.sv
module tb_i2s_feed;

  localparam int FRAME  = 1024;
  localparam int SFRAME = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic        valid, s_valid;
  logic        ready, s_ready;
  logic [15:0] dl, dr, s_dl, s_dr;
  logic        mute, s_mute;
  logic        clear, s_clear;
  logic [15:0] l, r, s_l, s_r;
  logic        fs, s_fs;
  logic [2:0]  level, s_level;
  logic [7:0]  ucnt, s_ucnt;

  int total = 0;
  int fails = 0;

  always #5 clock = ~clock;

  i2s_feed #(.DEPTH(4), .FRAME(FRAME)) dut (
    .clock(clock), .reset(reset), .valid(valid), .ready(ready),
    .dl(dl), .dr(dr), .mute(mute), .clear(clear),
    .l(l), .r(r), .fs(fs), .level(level), .ucnt(ucnt)
  );

  // Short-frame instance for the long underflow-count sequence.
  i2s_feed #(.DEPTH(4), .FRAME(SFRAME)) sdut (
    .clock(clock), .reset(reset), .valid(s_valid), .ready(s_ready),
    .dl(s_dl), .dr(s_dr), .mute(s_mute), .clear(s_clear),
    .l(s_l), .r(s_r), .fs(s_fs), .level(s_level), .ucnt(s_ucnt)
  );

  typedef struct {
    int          npush;
    logic [15:0] w0l, w0r, w1l, w1r;
    logic        mu;
    logic [15:0] el, er;
    int          elev;
    int          eucnt;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_fs(input bit sel, input int bound, output int n);
    bit seen;
    seen = 1'b0;
    n = 0;
    for (int i = 0; i < bound; i++) begin
      step();
      n++;
      if ((sel ? s_fs : fs) == 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      total++;
      fails++;
      $display("FAIL fs_timeout: no strobe within %0d clocks", bound);
    end
  endtask

  task automatic push(input bit sel, input logic [15:0] a, input logic [15:0] b);
    bit done;
    done = 1'b0;
    if (sel) begin s_dl = a; s_dr = b; s_valid = 1'b1; end
    else     begin dl = a;   dr = b;   valid = 1'b1;   end
    for (int i = 0; i < 4 * FRAME; i++) begin
      if ((sel ? s_ready : ready) == 1'b1) begin
        step();
        done = 1'b1;
        break;
      end
      step();
    end
    if (sel) s_valid = 1'b0;
    else     valid = 1'b0;
    if (!done) begin
      total++;
      fails++;
      $display("FAIL push_timeout: ready never asserted");
    end
  endtask

  initial begin
    int n, accepted, popped, nfs, cyc;
    logic rd;

    tbl[0] = '{2, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 1'b0, 16'h1111, 16'h2222, 1, 0};
    tbl[1] = '{0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h3333, 16'h4444, 0, 0};
    tbl[2] = '{0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h3333, 16'h4444, 0, 1};
    tbl[3] = '{0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000, 0, 1};
    tbl[4] = '{1, 16'hAAAA, 16'h5555, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1, 1};
    tbl[5] = '{1, 16'h8000, 16'h7FFF, 16'h0000, 16'h0000, 1'b0, 16'hAAAA, 16'h5555, 1, 1};
    tbl[6] = '{1, 16'h0001, 16'hFFFF, 16'h0000, 16'h0000, 1'b1, 16'h0000, 16'h0000, 1, 1};
    tbl[7] = '{0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0001, 16'hFFFF, 0, 1};
    tbl[8] = '{0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1, 16'h0000, 16'h0000, 0, 2};
    tbl[9] = '{0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000, 0, 2};

    reset = 1'b0; valid = 1'b0; dl = '0; dr = '0; mute = 1'b0; clear = 1'b0;
    s_valid = 1'b0; s_dl = '0; s_dr = '0; s_mute = 1'b0; s_clear = 1'b0;
    step();
    step();
    chk("rst_level", level, 0);
    chk("rst_ready", ready, 1);
    chk("rst_l", l, 0);
    chk("rst_r", r, 0);
    chk("rst_fs", fs, 0);
    chk("rst_ucnt", ucnt, 0);
    reset = 1'b1;

    // Idle priming frames: strobe every FRAME clocks, zeros out.
    for (int f = 0; f < 3; f++) begin
      wait_fs(1'b0, FRAME + 8, n);
      chk("idle_fs_period", n, FRAME);
      chk("idle_l", l, 0);
      chk("idle_r", r, 0);
      chk("idle_ucnt", ucnt, 0);
    end
    step();
    chk("fs_one_cycle", fs, 0);

    // Frame-by-frame vectors.
    for (int i = 0; i < 10; i++) begin
      mute = tbl[i].mu;
      if (tbl[i].npush >= 1) push(1'b0, tbl[i].w0l, tbl[i].w0r);
      if (tbl[i].npush >= 2) push(1'b0, tbl[i].w1l, tbl[i].w1r);
      wait_fs(1'b0, FRAME + 8, n);
      chk($sformatf("vec%0d_l", i), l, tbl[i].el);
      chk($sformatf("vec%0d_r", i), r, tbl[i].er);
      chk($sformatf("vec%0d_level", i), level, tbl[i].elev);
      chk($sformatf("vec%0d_ucnt", i), ucnt, tbl[i].eucnt);
    end
    mute = 1'b0;

    // Continuous valid: fill to 4, then one accepted push per pop, in order.
    accepted = 0; popped = 0; nfs = 0; cyc = 0;
    valid = 1'b1;
    while (nfs < 3 && cyc < 4 * FRAME) begin
      dl = 16'h1000 + 16'(accepted);
      dr = 16'h2000 + 16'(accepted);
      rd = ready;
      step();
      cyc++;
      if (rd) accepted++;
      if (cyc == 20) begin
        chk("full_level", level, 4);
        chk("full_ready", ready, 0);
        chk("full_accepted", accepted, 4);
      end
      if (fs) begin
        chk("stream_l", l, 32'h1000 + popped);
        chk("stream_r", r, 32'h2000 + popped);
        popped++;
        chk("stream_level", level, 3);
        chk("stream_accepted", accepted, popped + 3);
        nfs++;
      end
    end
    if (nfs < 3) chk("stream_fs_count", nfs, 3);
    dl = 16'h1000 + 16'(accepted);
    dr = 16'h2000 + 16'(accepted);
    rd = ready;
    step();
    if (rd) accepted++;
    valid = 1'b0;
    chk("refill_level", level, 4);
    chk("refill_ready", ready, 0);
    chk("refill_accepted", accepted, 7);

    // Mute with 4 queued: zeros out, still pops; then next word appears.
    mute = 1'b1;
    wait_fs(1'b0, FRAME + 8, n);
    chk("mute_l", l, 0);
    chk("mute_r", r, 0);
    chk("mute_level", level, 3);
    mute = 1'b0;
    wait_fs(1'b0, FRAME + 8, n);
    chk("unmute_l", l, 16'h1004);
    chk("unmute_r", r, 16'h2004);
    chk("unmute_level", level, 2);

    // Mid-frame reset with level 3, push in the reset cycle is dropped.
    push(1'b0, 16'h5A5A, 16'hA5A5);
    for (int i = 0; i < 100; i++) step();
    chk("pre_rst_level", level, 3);
    reset = 1'b0;
    valid = 1'b1; dl = 16'h7777; dr = 16'h8888;
    step();
    valid = 1'b0;
    chk("midrst_level", level, 0);
    chk("midrst_l", l, 0);
    chk("midrst_r", r, 0);
    chk("midrst_fs", fs, 0);
    chk("midrst_ucnt", ucnt, 0);
    chk("midrst_ready", ready, 1);
    reset = 1'b1;
    wait_fs(1'b0, FRAME + 8, n);
    chk("midrst_fs_period", n, FRAME);
    chk("midrst_first_l", l, 0);
    chk("midrst_first_level", level, 0);

    // Underflow counter saturation and clear priority (short-frame instance).
    for (int k = 1; k <= 299; k++) begin
      push(1'b1, 16'hC001, 16'hC002);
      push(1'b1, 16'hD001, 16'hD002);
      for (int f = 0; f < 3; f++) wait_fs(1'b1, SFRAME + 4, n);
      if (k == 10)  chk("ucnt_10", s_ucnt, 10);
      if (k == 255) chk("ucnt_255", s_ucnt, 255);
    end
    chk("ucnt_sat", s_ucnt, 255);
    push(1'b1, 16'hC001, 16'hC002);
    push(1'b1, 16'hD001, 16'hD002);
    wait_fs(1'b1, SFRAME + 4, n);
    wait_fs(1'b1, SFRAME + 4, n);
    chk("pre_clear_l", s_l, 16'hD001);
    chk("pre_clear_level", s_level, 0);
    for (int i = 0; i < SFRAME - 1; i++) step();
    s_clear = 1'b1;
    step();
    s_clear = 1'b0;
    chk("clear_fs", s_fs, 1);
    chk("clear_ucnt", s_ucnt, 0);
    chk("clear_hold_l", s_l, 16'hD001);
    chk("clear_hold_r", s_r, 16'hD002);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
